spi_slave: RTL and testbench



---
 rtl/spi_slave.sv | 164 ++++++++++++++++
 tb/tb_spi_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples scl/ss/mosi on clk, shifts a 128-bit word out on miso
// and collects up to the last 128 received bits, reporting master-style status.
module spi_slave #(
    parameter logic CPOL = 1'b1,
    parameter logic CPHA = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [127:0] slv_wfifo,
    input  logic [7:0]   slv_ctrl,
    output logic [127:0] slv_rfifo,
    output logic [7:0]   slv_status,
    input  logic         scl,
    input  logic         ss,
    input  logic         mosi,
    output logic         miso
);

    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_END    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic scl_p0, scl_p1, scl_p2;
    logic ss_p0, ss_p1, ss_p2;
    logic mosi_p0, mosi_p1;

    logic scl_rise, scl_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, ss_rise;
    logic frame_start, frame_end, active;

    logic [DATA_W-1:0] tx_buf, tx_nxt;
    logic [DATA_W-1:0] rx_buf;
    logic [2:0]        bit_cnt;
    logic [4:0]        byte_cnt;
    logic              first_shift;
    logic              done;
    logic              frame_err;
    logic              ctrl_unused;

    assign ctrl_unused = ^{slv_ctrl[7], slv_ctrl[5:1]};

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd16) ? v : v + 5'd1;
    endfunction

    // Stage p0/p1: two-flop synchronisers; p2: history for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_p0  <= CPOL;
            scl_p1  <= CPOL;
            scl_p2  <= CPOL;
            ss_p0   <= 1'b1;
            ss_p1   <= 1'b1;
            ss_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            scl_p0  <= scl;
            scl_p1  <= scl_p0;
            scl_p2  <= scl_p1;
            ss_p0   <= ss;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign scl_rise    = scl_p1 & ~scl_p2;
    assign scl_fall    = ~scl_p1 & scl_p2;
    assign lead_edge   = CPOL ? scl_fall : scl_rise;
    assign trail_edge  = CPOL ? scl_rise : scl_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_p1 & ss_p2;
    assign ss_rise     = ss_p1 & ~ss_p2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall && slv_ctrl[0]) begin
                    state_nxt   = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: if (ss_rise) state_nxt = ST_END;
            ST_END:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign active    = (state == ST_ACTIVE);
    assign frame_end = (state == ST_END);

    // With CPHA=1 the first shift edge only arms the pipeline so the MSB meets the first sample
    always_comb begin
        tx_nxt = tx_buf;
        if (frame_start)
            tx_nxt = slv_wfifo;
        else if (active && shift_edge && !(CPHA && first_shift))
            tx_nxt = {tx_buf[DATA_W-2:0], 1'b0};
    end

    // Stage p3: frame registers, updated one cycle after the synced edge pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_buf      <= '0;
            rx_buf      <= '0;
            slv_rfifo   <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            first_shift <= 1'b0;
            frame_err   <= 1'b0;
            done        <= 1'b0;
            miso        <= 1'b0;
        end else begin
            tx_buf <= tx_nxt;
            miso   <= (state_nxt == ST_ACTIVE) ? tx_nxt[DATA_W-1] : 1'b0;

            if (frame_start) begin
                rx_buf      <= '0;
                bit_cnt     <= '0;
                byte_cnt    <= '0;
                frame_err   <= 1'b0;
                first_shift <= 1'b1;
            end else if (active) begin
                if (sample_edge) begin
                    rx_buf  <= {rx_buf[DATA_W-2:0], mosi_p1};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        byte_cnt <= sat_inc(byte_cnt);
                end
                if (shift_edge)
                    first_shift <= 1'b0;
            end

            if (frame_end) begin
                slv_rfifo <= rx_buf;
                frame_err <= (bit_cnt != 3'd0);
            end

            if (frame_end)
                done <= 1'b1;
            else if (slv_ctrl[6])
                done <= 1'b0;
        end
    end

    assign slv_status = {(state != ST_IDLE), done, frame_err, byte_cnt};

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one master drives a CPOL=1/CPHA=1 and a CPOL=0/CPHA=0 slave together,
// checking miso, receive word and status against a bit-list model of each frame.
module tb_spi_slave;

    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] wfifo;
    logic [7:0]   ctrl;
    logic         scl, ss, mosi;
    logic         scl_b;
    logic [127:0] rfifo_a, rfifo_b;
    logic [7:0]   status_a, status_b;
    logic         miso_a, miso_b;

    assign scl_b = ~scl;

    always #5 clk = ~clk;

    spi_slave #(.CPOL(1'b1), .CPHA(1'b1)) u_a (
        .clk(clk), .rstn(rstn), .slv_wfifo(wfifo), .slv_ctrl(ctrl),
        .slv_rfifo(rfifo_a), .slv_status(status_a),
        .scl(scl), .ss(ss), .mosi(mosi), .miso(miso_a)
    );

    spi_slave #(.CPOL(1'b0), .CPHA(1'b0)) u_b (
        .clk(clk), .rstn(rstn), .slv_wfifo(wfifo), .slv_ctrl(ctrl),
        .slv_rfifo(rfifo_b), .slv_status(status_b),
        .scl(scl_b), .ss(ss), .mosi(mosi), .miso(miso_b)
    );

    int errors = 0;
    int checks = 0;

    bit           mb [0:255];
    logic [127:0] exp_rfifo;
    logic [7:0]   exp_status;
    bit           chk_idle;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic exp_bit(input logic [127:0] tx, input int i);
        return (i < 128) ? tx[127 - i] : 1'b0;
    endfunction

    // receive word = last min(n,128) bits received, most recent at bit 0
    function automatic logic [127:0] model_rx(input int nb);
        logic [127:0] r = '0;
        for (int k = 0; k < nb && k < 128; k++) r[k] = mb[nb - 1 - k];
        return r;
    endfunction

    function automatic logic [7:0] model_status(input int nb);
        int bytes = (nb / 8 > 16) ? 16 : nb / 8;
        return {1'b0, 1'b1, (nb % 8) != 0, 5'(bytes)};
    endfunction

    task automatic set_byte(input int idx, input logic [7:0] b);
        for (int j = 0; j < 8; j++) mb[idx * 8 + j] = b[7 - j];
    endtask

    always @(negedge clk) begin
        if (chk_idle && rstn) begin
            chk("idle_miso_a", miso_a, 1'b0);
            chk("idle_miso_b", miso_b, 1'b0);
            chk("idle_status_a", status_a, exp_status);
            chk("idle_status_b", status_b, exp_status);
            chk("idle_rfifo_a", rfifo_a, exp_rfifo);
            chk("idle_rfifo_b", rfifo_b, exp_rfifo);
        end
    end

    task automatic run_frame(input logic [127:0] tx, input int nb, input int h, input bit hold_clr);
        chk_idle = 1'b0;
        wfifo = tx;
        wait_clk(1);
        ss = 1'b0;
        wait_clk(2);
        chk("pre_start_miso_b", miso_b, 1'b0);
        wait_clk(1);
        chk("first_miso_b", miso_b, tx[127]);
        chk("first_miso_a", miso_a, tx[127]);
        chk("start_busy_a", status_a[7], 1'b1);
        wait_clk(3);
        for (int i = 0; i < nb; i++) begin
            mosi = mb[i];
            wait_clk(2);
            chk("miso_b", miso_b, exp_bit(tx, i));
            scl = 1'b0;
            wait_clk(h);
            chk("miso_a", miso_a, exp_bit(tx, i));
            scl = 1'b1;
            wait_clk(h - 2);
        end
        wait_clk(2);
        ss = 1'b1;
        if (hold_clr) ctrl[6] = 1'b1;
        wait_clk(3);
        chk("end_busy_a", status_a[7], 1'b1);
        chk("end_busy_b", status_b[7], 1'b1);
        wait_clk(1);
        exp_rfifo  = model_rx(nb);
        exp_status = model_status(nb);
        chk("end_rfifo_a", rfifo_a, exp_rfifo);
        chk("end_rfifo_b", rfifo_b, exp_rfifo);
        chk("end_status_a", status_a, exp_status);
        chk("end_status_b", status_b, exp_status);
        if (hold_clr) begin
            wait_clk(1);
            exp_status[6] = 1'b0;
            chk("clr_status_a", status_a, exp_status);
            chk("clr_status_b", status_b, exp_status);
            ctrl[6] = 1'b0;
        end
        mosi = 1'b0;
        wait_clk(2);
        chk_idle = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, h;
        logic [127:0] tx;

        chk_idle   = 1'b0;
        rstn       = 1'b0;
        wfifo      = '0;
        ctrl       = 8'h01;
        scl        = 1'b1;
        ss         = 1'b1;
        mosi       = 1'b0;
        exp_rfifo  = '0;
        exp_status = 8'h00;
        wait_clk(4);
        rstn = 1'b1;
        wait_clk(1);
        chk_idle = 1'b1;
        wait_clk(4);

        // single byte, 16-clk scl period
        set_byte(0, 8'h5A);
        run_frame(128'hA5 << 120, 8, 8, 1'b0);
        chk("t2_rfifo_a", rfifo_a, 128'h5A);
        chk("t2_status_a", status_a, 8'h41);
        chk("t2_rfifo_b", rfifo_b, 128'h5A);

        // three bytes
        set_byte(0, 8'h12); set_byte(1, 8'h34); set_byte(2, 8'h56);
        run_frame({32'hC3A5_0F96, 96'h0}, 24, 6, 1'b0);
        chk("t3_rfifo_b", rfifo_b, 128'h123456);
        chk("t3_status_b", status_b, 8'h43);

        // partial byte 10110
        mb[0] = 1; mb[1] = 0; mb[2] = 1; mb[3] = 1; mb[4] = 0;
        run_frame({$urandom, $urandom, $urandom, $urandom}, 5, 5, 1'b0);
        chk("t4_rfifo_a", rfifo_a, 128'h16);
        chk("t4_status_a", status_a, 8'h60);
        chk("t4_status_b", status_b, 8'h60);

        // overrun: 17 bytes 00..10
        for (int b = 0; b < 17; b++) set_byte(b, 8'(b));
        run_frame({$urandom, $urandom, $urandom, $urandom}, 136, 4, 1'b0);
        chk("t5_rfifo_a", rfifo_a, 128'h0102030405060708090A0B0C0D0E0F10);
        chk("t5_status_a", status_a, 8'h50);
        chk("t5_rfifo_b", rfifo_b, 128'h0102030405060708090A0B0C0D0E0F10);

        // done-clear held through the end cycle: set wins, then clears
        set_byte(0, 8'hC3);
        run_frame({$urandom, $urandom, $urandom, $urandom}, 8, 4, 1'b1);
        chk("t6_done_cleared_a", status_a[6], 1'b0);

        // enable low: ss falling must not start a frame
        ctrl[0] = 1'b0;
        wait_clk(1);
        ss = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 4; i++) begin
            scl = ~scl;
            wait_clk(4);
        end
        chk("t6_en_busy_a", status_a[7], 1'b0);
        chk("t6_en_miso_b", miso_b, 1'b0);
        ss = 1'b1;
        wait_clk(4);
        ctrl[0] = 1'b1;
        wait_clk(4);

        // randomized frames
        for (int r = 0; r < 12; r++) begin
            nb = $urandom_range(1, 140);
            h  = $urandom_range(4, 8);
            tx = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < nb; i++) mb[i] = 1'($urandom);
            run_frame(tx, nb, h, 1'($urandom_range(0, 3) == 0));
            wait_clk($urandom_range(0, 5));
        end

        // reset in the middle of a frame
        chk_idle = 1'b0;
        wfifo = {4{32'hFFFF_FFFF}};
        ss = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            wait_clk(2);
            scl = 1'b0;
            wait_clk(4);
            scl = 1'b1;
            wait_clk(2);
        end
        scl  = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_miso_a", miso_a, 1'b0);
        chk("rst_miso_b", miso_b, 1'b0);
        chk("rst_status_a", status_a, 8'h00);
        chk("rst_rfifo_a", rfifo_a, 128'h0);
        chk("rst_rfifo_b", rfifo_b, 128'h0);
        wait_clk(2);
        scl  = 1'b1;
        ss   = 1'b1;
        mosi = 1'b0;
        wait_clk(3);
        rstn       = 1'b1;
        exp_rfifo  = '0;
        exp_status = 8'h00;
        chk_idle   = 1'b1;
        wait_clk(10);

        // a clean frame after reset
        set_byte(0, 8'h81); set_byte(1, 8'h7E);
        run_frame({$urandom, $urandom, $urandom, $urandom}, 16, 8, 1'b0);
        chk("post_rst_status_a", status_a, 8'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
